uart_packet_rx: RTL and testbench
=================================

# uart_packet_rx

FPGA-side receiver for the host UART command link. It deserialises 8N1 UART bytes from the host and assembles each group of `MSG_WIDTH/DATA_WIDTH` bytes, least-significant byte first, into one message. Each message is presented as header plus payload on a valid/ready interface. It sits between `uart_rx_pin` and the command decoder that dispatches the mem-params, mod-params, demod-params, sys-status and replace-num headers.

## Interface
- `CLK_RATE`, 81_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate.
- `DATA_WIDTH`, 8: data bits per UART word.
- `STOP_BITS`, 1: stop bits per word.
- `MSG_WIDTH`, 64: message width; must be a multiple of `DATA_WIDTH`.
- `HEADER_WIDTH`, 8: header field width.
- `TIMEOUT_BAUDS`, 20: idle bit periods after which a partial message is discarded.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_pin`  in  1  asynchronous UART line; idle high.
- `msg_valid`  out  1  a message is held.
- `msg_ready`  in  1  consumer accepts the message.
- `msg_header`  out  `HEADER_WIDTH`  message bits `[MSG_WIDTH-1 -: HEADER_WIDTH]`.
- `msg_payload`  out  `MSG_WIDTH-HEADER_WIDTH`  message bits `[MSG_WIDTH-HEADER_WIDTH-1:0]`.
- `framing_error`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overflow`  out  1  one-cycle pulse when a message completes while `msg_valid` is already high.

## Operation
- `rx_pin` passes through a 2-FF synchroniser, reset to 1.
- Derived constants: `CLKS_PER_BAUD = CLK_RATE/BAUD` (integer division) and `HALF = CLKS_PER_BAUD/2`.
- The bit counter is sized by `$clog2(CLKS_PER_BAUD)`.
- Word FSM:
  - IDLE: on synchronised line = 0, go to START and load `HALF`.
  - START: at count expiry, if line = 0, go to DATA and load `CLKS_PER_BAUD`. If line = 1, treat it as a glitch and return to IDLE; nothing is emitted.
  - DATA: sample the line at each expiry into a shift register, LSB first. After `DATA_WIDTH` samples, go to STOP.
  - STOP: sample at each expiry, `STOP_BITS` times.
    - All samples 1: the word is good; go to IDLE.
    - Any sample 0: pulse `framing_error`, discard the word, clear the packet byte index, go to IDLE. Waiting for the line to return high is implicit, because IDLE waits for a falling level.
- Packet assembly:
  - Each good word is written into message byte `byte_idx`, and `byte_idx` increments.
  - When `byte_idx` reaches `MSG_WIDTH/DATA_WIDTH - 1` and that word is good, the message is complete and `byte_idx` wraps to 0.
- Output register (1 deep):
  - On completion with `msg_valid` = 0: load `msg_header`/`msg_payload` and set `msg_valid`.
  - On completion with `msg_valid` = 1 and no handshake that cycle: keep the held message, drop the new one, pulse `overflow`.
  - On completion in the same cycle as `msg_valid && msg_ready`: load the new message and keep `msg_valid` = 1; no overflow.
  - `msg_valid` clears on `msg_valid && msg_ready` when there is no simultaneous completion.
- Timeout: see Configuration.

## Timing
- Reset values:
  - `msg_valid` = 0; `msg_header` and `msg_payload` = 0.
  - `framing_error` and `overflow` = 0.
  - FSM = IDLE, `byte_idx` = 0, synchroniser = 1.
- Reset asserted mid-word or mid-packet discards all partial state. The next falling edge after reset starts a new word.
- Pin to FSM latency is 2 cycles (synchroniser).
- Sampling points fall `HALF + k*CLKS_PER_BAUD` cycles after the detected falling edge, ±1 cycle.
- `msg_valid` rises on the cycle after the last stop-bit sample of the final byte.
- `framing_error` pulses on the cycle after the bad stop sample.
- `overflow` pulses on the cycle after the completing sample.
- Outputs are stable while `msg_valid` = 1 and `msg_ready` = 0.
- `msg_valid` is not combinationally dependent on `msg_ready`.

## Configuration
- Macro: `UART_PACKET_RX_TIMEOUT_EN`.
- With the macro defined:
  - An idle counter runs while FSM = IDLE and `byte_idx` ≠ 0.
  - When it reaches `TIMEOUT_BAUDS*CLKS_PER_BAUD` cycles, `byte_idx` is cleared and the partial message is discarded silently.
  - The counter resets on every start bit.
- Without the macro: no counter exists, and a partial message persists indefinitely until completed, ended by a framing error, or cleared by reset.

## Test plan
- **Basic message:** 81 MHz, 9600 baud (`CLKS_PER_BAUD` = 8437). Send bytes 0x01..0x08 with `msg_ready` = 1 → one `msg_valid` pulse with `msg_header` = 0x08 and `msg_payload` = 0x07060504030201.
- **Glitch rejection:** a 100-cycle low pulse on `rx_pin`, then a valid 8-byte packet → no spurious byte, no `framing_error`, and exactly one correct message.
- **Framing error:** send 3 good bytes, then a byte with its stop bit held 0, then bytes 0x11..0x18 → one `framing_error` pulse, then exactly one message with `msg_header` = 0x18 and `msg_payload` = 0x17161514131211.
- **Backpressure and overflow:** with `msg_ready` = 0, send two packets A and B → `msg_valid` holds A unchanged and `overflow` pulses once at the end of B. Then raise `msg_ready` → `msg_valid` drops after one handshake.
- **Timeout (macro defined):** send 3 bytes, idle 25 bit times, then send 0x21..0x28 → one message with `msg_header` = 0x28 and `msg_payload` = 0x27262524232221. With the macro undefined, the same stimulus produces a message built from the first 3 bytes plus 0x21..0x25.
- **Reset mid-operation:** assert `reset` for 1 cycle in the middle of byte 5 → outputs return to their reset values, and a following full packet is received correctly.

Source files
------------

// File: rtl/uart_packet_rx.sv
// uart_packet_rx
// Host command-link receiver: deserialises 8N1 UART words from rx_pin and
// packs MSG_WIDTH/DATA_WIDTH consecutive good words (least-significant word
// first) into one message, offered as header + payload on a 1-deep
// valid/ready output register.
//
// Optional build macro: UART_PACKET_RX_TIMEOUT_EN
//   defined   - a partial message is dropped after TIMEOUT_BAUDS idle bit
//               periods between words.
//   undefined - a partial message waits indefinitely for its remaining words.
//
// Word FSM
//   state   | meaning
//   S_IDLE  | line idle, waiting for a low level (start of a start bit)
//   S_START | half a bit period in, confirming the start bit is still low
//   S_DATA  | sampling DATA_WIDTH data bits, one per bit period, LSB first
//   S_STOP  | sampling STOP_BITS stop bits; any low sample is a framing error

module uart_packet_rx #(
   parameter int CLK_RATE      = 81_000_000,
   parameter int BAUD          = 9600,
   parameter int DATA_WIDTH    = 8,
   parameter int STOP_BITS     = 1,
   parameter int MSG_WIDTH     = 64,
   parameter int HEADER_WIDTH  = 8,
   parameter int TIMEOUT_BAUDS = 20
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                rx_pin,
   output logic                                msg_valid,
   input  logic                                msg_ready,
   output logic [HEADER_WIDTH-1:0]             msg_header,
   output logic [MSG_WIDTH-HEADER_WIDTH-1:0]   msg_payload,
   output logic                                framing_error,
   output logic                                overflow
);

   localparam int CLKS_PER_BAUD = CLK_RATE / BAUD;
   localparam int HALF          = CLKS_PER_BAUD / 2;
   localparam int CNT_W         = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
   localparam int NUM_WORDS     = MSG_WIDTH / DATA_WIDTH;
   localparam int IDX_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int BIT_W         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int STOP_W        = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
   localparam int PAYLOAD_W     = MSG_WIDTH - HEADER_WIDTH;
   localparam int BUF_W         = MSG_WIDTH - DATA_WIDTH;

   // The bit timer is a down-counter that expires at zero, so it is loaded
   // with (period - 1); this keeps a full bit period inside $clog2 bits.
   localparam logic [CNT_W-1:0]  LOAD_BAUD = CNT_W'(CLKS_PER_BAUD - 1);
   localparam logic [CNT_W-1:0]  LOAD_HALF = CNT_W'((HALF > 0) ? HALF - 1 : 0);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
   localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);
   localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t              state;
   state_t              state_next;

   logic                rx_meta;
   logic                rx_sync;

   logic [CNT_W-1:0]    bit_cnt;
   logic                cnt_expired;
   logic                load_half;
   logic                load_baud;

   logic [BIT_W-1:0]    bit_idx;
   logic [STOP_W-1:0]   stop_idx;
   logic                stop_bad;
   logic [DATA_WIDTH-1:0] shift_word;
   logic                shift_en;
   logic                stop_sample;
   logic                word_done;
   logic                word_good;
   logic                word_bad;
   logic                start_bit;

   logic [IDX_W-1:0]    byte_idx;
   logic [BUF_W-1:0]    msg_buf;
   logic [MSG_WIDTH-1:0] msg_full;
   logic                msg_complete;
   logic                timeout_hit;

   // Two-flop synchroniser; resets to the idle-high line level.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx_pin;
         rx_sync <= rx_meta;
      end
   end

   assign cnt_expired = (bit_cnt == '0);
   assign start_bit   = (state == S_IDLE) && !rx_sync;

   // Word FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Word FSM next state and per-cycle sampling strobes.
   always_comb begin
      state_next  = state;
      load_half   = 1'b0;
      load_baud   = 1'b0;
      shift_en    = 1'b0;
      stop_sample = 1'b0;
      word_done   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rx_sync) begin
               state_next = S_START;
               load_half  = 1'b1;
            end
         end
         S_START: begin
            if (cnt_expired) begin
               if (!rx_sync) begin
                  state_next = S_DATA;
                  load_baud  = 1'b1;
               end else begin
                  // Line went back high before mid-bit: a glitch, not a word.
                  state_next = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (cnt_expired) begin
               shift_en  = 1'b1;
               load_baud = 1'b1;
               if (bit_idx == LAST_BIT) begin
                  state_next = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (cnt_expired) begin
               stop_sample = 1'b1;
               load_baud   = 1'b1;
               if (stop_idx == LAST_STOP) begin
                  word_done  = 1'b1;
                  state_next = S_IDLE;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // The final stop sample is folded in here so the verdict is available in
   // the same cycle as the sample itself.
   assign word_good = word_done && rx_sync && !stop_bad;
   assign word_bad  = word_done && !(rx_sync && !stop_bad);

   // Bit-period down-counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt <= '0;
      end else if (load_half) begin
         bit_cnt <= LOAD_HALF;
      end else if (load_baud) begin
         bit_cnt <= LOAD_BAUD;
      end else if (!cnt_expired) begin
         bit_cnt <= bit_cnt - 1'b1;
      end
   end

   // Data-bit position and LSB-first shift register.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_idx    <= '0;
         shift_word <= '0;
      end else begin
         if (state != S_DATA) begin
            bit_idx <= '0;
         end else if (shift_en) begin
            bit_idx <= bit_idx + 1'b1;
         end
         if (shift_en) begin
            shift_word <= {rx_sync, shift_word[DATA_WIDTH-1:1]};
         end
      end
   end

   // Stop-bit position and sticky bad-stop flag for multi-stop-bit framing.
   always_ff @(posedge clk) begin
      if (reset) begin
         stop_idx <= '0;
         stop_bad <= 1'b0;
      end else if (state != S_STOP) begin
         stop_idx <= '0;
         stop_bad <= 1'b0;
      end else if (stop_sample) begin
         stop_idx <= stop_idx + 1'b1;
         stop_bad <= stop_bad | !rx_sync;
      end
   end

`ifdef UART_PACKET_RX_TIMEOUT_EN
   localparam int TO_CYCLES = TIMEOUT_BAUDS * CLKS_PER_BAUD;
   localparam int TO_W      = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_CYCLES - 1);

   logic [TO_W-1:0] idle_cnt;
   logic            idle_counting;

   assign idle_counting = (state == S_IDLE) && (byte_idx != '0) && !start_bit;
   assign timeout_hit   = idle_counting && (idle_cnt == '0);

   // Inter-word idle timer; held at its load value except while a partial
   // message sits in IDLE, so every start bit restarts the full interval.
   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt <= TO_LOAD;
      end else if (!idle_counting) begin
         idle_cnt <= TO_LOAD;
      end else if (idle_cnt != '0) begin
         idle_cnt <= idle_cnt - 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign msg_complete = word_good && (byte_idx == LAST_WORD);
   // The last word goes straight from the shift register to the output, so
   // the buffer only ever holds the words below it.
   assign msg_full     = {shift_word, msg_buf};

   // Packet assembly: word slot write and word index.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx <= '0;
         msg_buf  <= '0;
      end else begin
         if (word_bad) begin
            byte_idx <= '0;
         end else if (word_good) begin
            byte_idx <= msg_complete ? '0 : byte_idx + 1'b1;
         end else if (timeout_hit) begin
            byte_idx <= '0;
         end
         if (word_good && !msg_complete) begin
            for (int w = 0; w < NUM_WORDS - 1; w++) begin
               if (byte_idx == IDX_W'(w)) begin
                  msg_buf[w*DATA_WIDTH +: DATA_WIDTH] <= shift_word;
               end
            end
         end
      end
   end

   // One-deep output register with overflow and framing-error pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         msg_valid     <= 1'b0;
         msg_header    <= '0;
         msg_payload   <= '0;
         framing_error <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         framing_error <= word_bad;
         overflow      <= 1'b0;
         if (msg_complete) begin
            if (!msg_valid || msg_ready) begin
               msg_valid   <= 1'b1;
               msg_header  <= msg_full[MSG_WIDTH-1 -: HEADER_WIDTH];
               msg_payload <= msg_full[PAYLOAD_W-1:0];
            end else begin
               overflow    <= 1'b1;
            end
         end else if (msg_valid && msg_ready) begin
            msg_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Bench for uart_packet_rx, run at a reduced clock/baud ratio (16 clocks
// per bit) so packets are short. A queue-based reference model predicts
// messages, framing errors and overflows from the byte stream; a separate
// negedge monitor checks every presented message against that queue.

module tb_uart_packet_rx;

   localparam int CLK_RATE = 160;
   localparam int BAUD     = 10;
   localparam int CPB      = CLK_RATE / BAUD;
   localparam int TO_BAUDS = 20;
   localparam int NB       = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_pin = 1'b1;
   logic        msg_ready = 1'b1;
   logic        msg_valid;
   logic [7:0]  msg_header;
   logic [55:0] msg_payload;
   logic        framing_error;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_fe   = 0;
   int exp_ovf  = 0;
   int got_fe   = 0;
   int got_ovf  = 0;

   logic [63:0] exp_q[$];
   logic [7:0]  partial[$];

   uart_packet_rx #(
      .CLK_RATE      (CLK_RATE),
      .BAUD          (BAUD),
      .DATA_WIDTH    (8),
      .STOP_BITS     (1),
      .MSG_WIDTH     (64),
      .HEADER_WIDTH  (8),
      .TIMEOUT_BAUDS (TO_BAUDS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_pin        (rx_pin),
      .msg_valid     (msg_valid),
      .msg_ready     (msg_ready),
      .msg_header    (msg_header),
      .msg_payload   (msg_payload),
      .framing_error (framing_error),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: a message is the 8 most recent good bytes, first byte in the
   // least-significant position.
   function automatic logic [63:0] build_msg(input logic [7:0] last);
      logic [63:0] m;
      m = 64'(last) << 56;
      for (int i = 0; i < partial.size(); i++) begin
         m = m | (64'(partial[i]) << (8 * i));
      end
      return m;
   endfunction

   // Drives one 8N1 frame; abort_after >= 0 stops after that many bit periods.
   task automatic send_word(input logic [7:0] d, input logic stop_val, input int abort_after);
      logic [9:0] frame;
      frame = {stop_val, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (abort_after >= 0 && i >= abort_after) return;
         rx_pin = frame[i];
         repeat (CPB) tick();
      end
      rx_pin = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      rx_pin = 1'b1;
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] d);
      if (partial.size() == NB - 1) begin
         if (exp_q.size() != 0 && !msg_ready) exp_ovf++;
         else exp_q.push_back(build_msg(d));
         partial.delete();
      end else begin
         partial.push_back(d);
      end
      send_word(d, 1'b1, -1);
      idle_cycles($urandom_range(0, 2 * CPB));
   endtask

   task automatic send_bad_byte(input logic [7:0] d);
      partial.delete();
      exp_fe++;
      send_word(d, 1'b0, -1);
      idle_cycles(2 * CPB);
   endtask

   task automatic idle_bits(input int n);
      idle_cycles(n * CPB);
`ifdef UART_PACKET_RX_TIMEOUT_EN
      if (n > TO_BAUDS) partial.delete();
`endif
   endtask

   task automatic send_packet_random();
      for (int b = 0; b < NB; b++) send_byte(8'($urandom));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},   64'(msg_valid), 64'd0);
      check({tag, "_header"},  64'(msg_header), 64'd0);
      check({tag, "_payload"}, 64'(msg_payload), 64'd0);
      check({tag, "_ferr"},    64'(framing_error), 64'd0);
      check({tag, "_ovf"},     64'(overflow), 64'd0);
   endtask

   // Monitor: counts pulses and compares every presented message with the
   // oldest predicted one; the entry retires on a handshake.
   always @(negedge clk) begin
      if (!reset) begin
         if (framing_error) got_fe++;
         if (overflow) got_ovf++;
         if (msg_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_msg: got %h%h expected none", msg_header, msg_payload);
            end else begin
               check("msg_header", 64'(msg_header), 64'(exp_q[0][63:56]));
               check("msg_payload", 64'(msg_payload), 64'(exp_q[0][55:0]));
               if (msg_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      check_reset_outputs("reset");

      // Basic message 0x01..0x08
      idle_cycles(2 * CPB);
      for (int b = 1; b <= 8; b++) send_byte(8'(b));

      // Glitch shorter than half a bit, then a good packet
      rx_pin = 1'b0;
      repeat (4) tick();
      idle_cycles(2 * CPB);
      send_packet_random();

      // Framing error after 3 good bytes, then 0x11..0x18
      for (int b = 0; b < 3; b++) send_byte(8'($urandom));
      send_bad_byte(8'h5A);
      for (int b = 0; b < 8; b++) send_byte(8'(8'h11 + b));

      // Backpressure: A is held, B overflows
      idle_cycles(2 * CPB);
      msg_ready = 1'b0;
      send_packet_random();
      send_packet_random();
      idle_cycles(3 * CPB);
      check("overflow_seen", 64'(got_ovf), 64'(exp_ovf));
      msg_ready = 1'b1;
      tick();
      tick();
      check("valid_drop", 64'(msg_valid), 64'd0);

      // Timeout: 3 bytes, long idle, 0x21..0x28
      for (int b = 0; b < 3; b++) send_byte(8'(8'hA1 + b));
      idle_bits(25);
      for (int b = 0; b < 8; b++) send_byte(8'(8'h21 + b));

      // Reset in the middle of byte 5
      idle_cycles(2 * CPB);
      for (int b = 0; b < 4; b++) send_byte(8'($urandom));
      send_word(8'h00, 1'b1, 4);
      rx_pin = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      partial.delete();
      exp_q.delete();
      check_reset_outputs("midreset");
      idle_cycles(2 * CPB);
      send_packet_random();

      // Random traffic with occasional framing errors
      for (int p = 0; p < 6; p++) begin
         for (int b = 0; b < NB; b++) begin
            if ($urandom_range(0, 15) == 0) send_bad_byte(8'($urandom));
            send_byte(8'($urandom));
         end
      end

      for (int i = 0; i < 40 * CPB && exp_q.size() != 0; i++) tick();
      idle_cycles(4);
      check("pending_msgs", 64'(exp_q.size()), 64'd0);
      check("framing_count", 64'(got_fe), 64'(exp_fe));
      check("overflow_count", 64'(got_ovf), 64'(exp_ovf));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
